x_sram_arb: RTL and testbench
=============================

# x_sram_arb

Two-requester round-robin arbiter and sequencer in front of the sixteen `x_23K640_data` SPI SRAM channels. It takes flat 20-bit byte addresses from two independent requesters, for example the UART test driver and a future DMA engine. Bits [19:16] select the chip and bits [15:0] form the in-chip address. The block issues one transaction at a time to the selected channel and returns the completion, read data and an optional error flag to the requester that owns it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: cycles allowed from issue to channel completion before the transaction is aborted. Only used with the timeout macro; must be at least 2.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_a_valid`  in  1  requester A request; held until accepted.
- `o_a_accept`  out  1  one-cycle pulse: A's request has been captured.
- `i_a_rd_n_wr`  in  1  1 = read, 0 = write.
- `i_a_addr`  in  20  [19:16] chip, [15:0] address.
- `i_a_wdata`  in  8  write byte.
- `o_a_done`  out  1  one-cycle pulse: A's transaction has finished.
- `o_a_rdata`  out  8  read byte; valid while `o_a_done` is high.
- `o_a_err`  out  1  timeout flag; valid while `o_a_done` is high.
- `i_b_*` / `o_b_*`: identical set of ports for requester B.
- `o_valid`  out  16  one-hot request to the channels.
- `i_accept`  in  16  per-channel one-cycle pulse: request captured.
- `o_rd_n_wr`  out  1  shared to all channels.
- `o_addr`  out  16  shared to all channels.
- `o_wdata`  out  8  shared to all channels.
- `i_ready`  in  16  per-channel one-cycle completion pulse.
- `i_rdata`  in  128  channel n read byte at [8n+7:8n]; valid while `i_ready[n]` is high.

## Operation
State machine:
- IDLE
  - If either requester's valid is high, grant one of them.
  - Pulse that requester's accept in the same cycle.
  - Latch the owner, chip, rd_n_wr, address and wdata.
  - Go to ISSUE.
- ISSUE
  - Drive `o_valid[chip]` high, all other `o_valid` bits 0.
  - Drive the latched command on `o_rd_n_wr`, `o_addr`, `o_wdata`.
  - On `i_accept[chip]`: drop `o_valid` in the next cycle and go to WAIT.
- WAIT
  - On `i_ready[chip]`: register `i_rdata[chip]` (0 for writes).
  - Next cycle: pulse the owner's done with that data, err = 0; go to IDLE.

Arbitration:
- Round-robin with a one-bit priority pointer; reset value favours A.
- Both requesters valid: the pointer side wins.
- After any grant the pointer moves to the other requester.
- A single valid requester is always granted, whatever the pointer says.

Ignored inputs:
- `i_accept` and `i_ready` bits for chips other than the latched one, in any state.
- `i_ready[chip]` arriving in ISSUE before `i_accept[chip]` (a protocol error; not flagged).
- Any `i_accept` or `i_ready` in IDLE.

Reset:
- Reset at any point, including mid-transaction, returns to IDLE with the pointer favouring A.
- The in-flight transaction is dropped with no done pulse.
- Every output resets to 0: `o_valid`, both accepts, both dones, both rdata, both err, `o_rd_n_wr`, `o_addr`, `o_wdata`.

## Timing
- Accept cycle T0; `o_valid` is high from T0+1.
- Channel accepts at Ta ≥ T0+1; `o_valid` is low from Ta+1.
- Channel ready at Tr > Ta; owner done at Tr+1.
- The block is back in IDLE at Tr+1, so a new grant (accept pulse) can occur at Tr+1.
- Only one transaction is ever outstanding.
- The shared command bus holds the latched values from T0+1 until the next grant.
- All outputs are registered except `o_a_accept` and `o_b_accept`, which are combinational from IDLE state, the valids and the pointer.

## Configuration
Macro `X_SRAM_ARB_TIMEOUT_EN`.

Defined:
- A counter clears at grant and increments every cycle in ISSUE and WAIT.
- If it reaches `TIMEOUT_CYCLES - 1` with no completion:
  - drop `o_valid` the next cycle;
  - pulse the owner's done with err = 1 and rdata = 0x00;
  - go to IDLE.
- Completion arriving in the same cycle as the terminal count wins, giving a normal done with err = 0.

Not defined:
- No counter.
- `o_a_err` and `o_b_err` are tied to 0.
- WAIT and ISSUE last indefinitely.

## Test plan
- A write 0x3_1234 = 0x5A (channel model accepts after 3 cycles, ready after 20):
  - `o_valid` = 0x0008, `o_addr` = 0x1234, `o_wdata` = 0x5A;
  - `o_a_done` exactly 1 cycle after `i_ready[3]`; err = 0.
- B read 0xF_0010, channel returns 0xC3:
  - `o_valid` = 0x8000;
  - `o_b_rdata` = 0xC3 with `o_b_done`.
- A and B valid in the same cycle after reset, then continuously:
  - grants alternate A, B, A, B;
  - each accept pulse falls exactly on the cycle the previous done pulses.
- During WAIT on chip 2, pulse `i_ready[5]` and `i_accept[2]`: no done.
  - Then pulse `i_ready[2]`: a single done.
- Assert `i_rst` in WAIT: the next cycle shows all outputs 0 and no done.
  - After reset, B alone valid: granted immediately.
- With `X_SRAM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, channel never asserts ready:
  - done with err = 1 and rdata = 0x00;
  - `o_valid` = 0 afterwards.
  - Without the macro, the block is still in WAIT after 1000 cycles.

Source files
------------

// File: rtl/x_sram_arb.sv
// Round-robin arbiter/sequencer between two requesters and sixteen SPI SRAM channels.
// Optional transaction timeout is enabled by defining X_SRAM_ARB_TIMEOUT_EN.
module x_sram_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_a_valid,
  output logic         o_a_accept,
  input  logic         i_a_rd_n_wr,
  input  logic [19:0]  i_a_addr,
  input  logic [7:0]   i_a_wdata,
  output logic         o_a_done,
  output logic [7:0]   o_a_rdata,
  output logic         o_a_err,
  input  logic         i_b_valid,
  output logic         o_b_accept,
  input  logic         i_b_rd_n_wr,
  input  logic [19:0]  i_b_addr,
  input  logic [7:0]   i_b_wdata,
  output logic         o_b_done,
  output logic [7:0]   o_b_rdata,
  output logic         o_b_err,
  output logic [15:0]  o_valid,
  input  logic [15:0]  i_accept,
  output logic         o_rd_n_wr,
  output logic [15:0]  o_addr,
  output logic [7:0]   o_wdata,
  input  logic [15:0]  i_ready,
  input  logic [127:0] i_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ptr;
  logic        r_owner;
  logic [3:0]  r_chip;
  logic [15:0] r_valid;
  logic [15:0] w_valid_nxt;
  logic        r_rd_n_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_a_done;
  logic        r_b_done;
  logic [7:0]  r_a_rdata;
  logic [7:0]  r_b_rdata;

  logic        w_idle;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_grant;
  logic [3:0]  w_new_chip;
  logic        w_acc_hit;
  logic        w_rdy_hit;
  logic        w_complete;
  logic        w_timeout;
  logic [7:0]  w_chip_rdata;
  logic [7:0]  w_done_data;

`ifdef X_SRAM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] r_cnt;
  logic          r_a_err;
  logic          r_b_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_grant) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A completion in the terminal-count cycle takes precedence over the abort.
  always_comb begin
    w_timeout = (r_state != S_IDLE) && (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !w_complete;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_err <= 1'b0;
      r_b_err <= 1'b0;
    end else begin
      r_a_err <= w_timeout && !r_owner;
      r_b_err <= w_timeout && r_owner;
    end
  end

  assign o_a_err = r_a_err;
  assign o_b_err = r_b_err;
`else
  always_comb begin
    w_timeout = 1'b0;
  end

  assign o_a_err = 1'b0;
  assign o_b_err = 1'b0;
`endif

  // Single valid requester always wins; on contention r_ptr (0 = A) decides.
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_grant_a  = w_idle && !i_rst && i_a_valid && (!i_b_valid || !r_ptr);
    w_grant_b  = w_idle && !i_rst && i_b_valid && (!i_a_valid || r_ptr);
    w_grant    = w_grant_a || w_grant_b;
    w_new_chip = w_grant_a ? i_a_addr[19:16] : i_b_addr[19:16];
  end

  always_comb begin
    w_acc_hit    = i_accept[r_chip];
    w_rdy_hit    = i_ready[r_chip];
    w_chip_rdata = i_rdata[{r_chip, 3'b000} +: 8];
    w_complete   = (r_state == S_WAIT) && w_rdy_hit;
    w_done_data  = r_rd_n_wr ? w_chip_rdata : 8'h00;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
          w_valid_nxt = 16'd1 << w_new_chip;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = '0;
        end else if (w_acc_hit) begin
          w_state_nxt = S_WAIT;
          w_valid_nxt = '0;
        end
      end
      S_WAIT: begin
        if (w_complete || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_ptr     <= 1'b0;
      r_owner   <= 1'b0;
      r_chip    <= '0;
      r_rd_n_wr <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      if (w_grant) begin
        r_ptr     <= w_grant_a;
        r_owner   <= w_grant_b;
        r_chip    <= w_new_chip;
        r_rd_n_wr <= w_grant_a ? i_a_rd_n_wr : i_b_rd_n_wr;
        r_addr    <= w_grant_a ? i_a_addr[15:0] : i_b_addr[15:0];
        r_wdata   <= w_grant_a ? i_a_wdata : i_b_wdata;
      end
      if (w_complete || w_timeout) begin
        if (r_owner) begin
          r_b_done  <= 1'b1;
          r_b_rdata <= w_complete ? w_done_data : 8'h00;
        end else begin
          r_a_done  <= 1'b1;
          r_a_rdata <= w_complete ? w_done_data : 8'h00;
        end
      end
    end
  end

  assign o_a_accept = w_grant_a;
  assign o_b_accept = w_grant_b;
  assign o_a_done   = r_a_done;
  assign o_b_done   = r_b_done;
  assign o_a_rdata  = r_a_rdata;
  assign o_b_rdata  = r_b_rdata;
  assign o_valid    = r_valid;
  assign o_rd_n_wr  = r_rd_n_wr;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;

endmodule

// File: tb/tb_x_sram_arb.sv
// Directed bench for x_sram_arb; timeout section follows X_SRAM_ARB_TIMEOUT_EN.
module tb_x_sram_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, a_accept, a_rd_n_wr, a_done, a_err;
  logic [19:0]  a_addr;
  logic [7:0]   a_wdata, a_rdata;
  logic         b_valid, b_accept, b_rd_n_wr, b_done, b_err;
  logic [19:0]  b_addr;
  logic [7:0]   b_wdata, b_rdata;
  logic [15:0]  valid, accept, ready, addr;
  logic         rd_n_wr;
  logic [7:0]   wdata;
  logic [127:0] rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  x_sram_arb #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_accept(a_accept), .i_a_rd_n_wr(a_rd_n_wr),
    .i_a_addr(a_addr), .i_a_wdata(a_wdata), .o_a_done(a_done),
    .o_a_rdata(a_rdata), .o_a_err(a_err),
    .i_b_valid(b_valid), .o_b_accept(b_accept), .i_b_rd_n_wr(b_rd_n_wr),
    .i_b_addr(b_addr), .i_b_wdata(b_wdata), .o_b_done(b_done),
    .o_b_rdata(b_rdata), .o_b_err(b_err),
    .o_valid(valid), .i_accept(accept), .o_rd_n_wr(rd_n_wr),
    .o_addr(addr), .o_wdata(wdata), .i_ready(ready), .i_rdata(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, 32'(valid), 32'h0);
    chk({tag, " cmd"}, {7'd0, rd_n_wr, addr, wdata}, 32'h0);
    chk({tag, " a out"}, {21'd0, a_accept, a_done, a_err, a_rdata}, 32'h0);
    chk({tag, " b out"}, {21'd0, b_accept, b_done, b_err, b_rdata}, 32'h0);
  endtask

  initial begin : stim
    logic seen;
    logic [7:0] exp_data;
    rst = 1'b1;
    a_valid = 1'b0; a_rd_n_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_rd_n_wr = 1'b0; b_addr = '0; b_wdata = '0;
    accept = '0; ready = '0; rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // A write 0x3_1234 = 0x5A, accept after 3 cycles, ready 20 later
    a_valid = 1'b1; a_rd_n_wr = 1'b0; a_addr = 20'h3_1234; a_wdata = 8'h5A;
    #1;
    chk("t1 accepts", {a_accept, b_accept}, 2'b10);
    tick();
    a_valid = 1'b0;
    chk("t1 valid", 32'(valid), 32'h0008);
    chk("t1 cmd", {7'd0, rd_n_wr, addr, wdata}, {7'd0, 1'b0, 16'h1234, 8'h5A});
    tick(); tick();
    chk("t1 valid held", 32'(valid), 32'h0008);
    accept = 16'h0008;
    tick();
    accept = '0;
    chk("t1 valid dropped", 32'(valid), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      seen |= a_done | b_done;
    end
    chk("t1 early done", 32'(seen), 32'h0);
    ready = 16'h0008; rdata = '1;
    tick();
    ready = '0; rdata = '0;
    chk("t1 done", {a_done, b_done, a_err, a_rdata}, {1'b1, 1'b0, 1'b0, 8'h00});
    tick();
    chk("t1 done pulse", {a_done, b_done}, 2'b00);

    // B read 0xF_0010 returns 0xC3
    b_valid = 1'b1; b_rd_n_wr = 1'b1; b_addr = 20'hF_0010; b_wdata = 8'h99;
    #1;
    chk("t2 accepts", {a_accept, b_accept}, 2'b01);
    tick();
    b_valid = 1'b0;
    chk("t2 valid", 32'(valid), 32'h8000);
    chk("t2 cmd", {15'd0, rd_n_wr, addr}, {15'd0, 1'b1, 16'h0010});
    accept = 16'h8000;
    tick();
    accept = '0;
    tick();
    ready = 16'h8000; rdata = '0; rdata[127:120] = 8'hC3; rdata[7:0] = 8'h11;
    tick();
    ready = '0; rdata = '0;
    chk("t2 done", {b_done, a_done, b_err, b_rdata}, {1'b1, 1'b0, 1'b0, 8'hC3});

    // Reset, then contention: grants A,B,A,B, each on the previous done cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_rd_n_wr = 1'b1; a_addr = 20'h1_0100;
    b_valid = 1'b1; b_rd_n_wr = 1'b1; b_addr = 20'h2_0200;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3 accepts", {a_accept, b_accept}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      chk("t3 valid", 32'(valid), (i % 2 == 0) ? 32'h0002 : 32'h0004);
      accept = (i % 2 == 0) ? 16'h0002 : 16'h0004;
      tick();
      accept = '0;
      exp_data = 8'h10 + 8'(i);
      ready = (i % 2 == 0) ? 16'h0002 : 16'h0004;
      rdata = {16{exp_data}};
      if (i == 3) begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      tick();
      ready = '0; rdata = '0;
      if (i % 2 == 0)
        chk("t3 a done", {a_done, b_done, a_rdata}, {2'b10, exp_data});
      else
        chk("t3 b done", {a_done, b_done, b_rdata}, {2'b01, exp_data});
    end
    chk("t3 final accepts", {a_accept, b_accept}, 2'b00);

    // Foreign and out-of-order handshakes are ignored
    a_valid = 1'b1; a_rd_n_wr = 1'b1; a_addr = 20'h2_0040;
    tick();
    a_valid = 1'b0;
    ready = 16'h0004; rdata = {16{8'hEE}};
    tick();
    ready = '0;
    chk("t4 ready in issue", {15'd0, a_done, valid}, 32'h0004);
    accept = 16'h0004;
    tick();
    accept = 16'h0004; ready = 16'h0020; rdata = {16{8'h66}};
    tick();
    accept = '0; ready = '0;
    chk("t4 foreign", {15'd0, a_done, valid}, 32'h0);
    tick();
    chk("t4 still waiting", {a_done, b_done}, 2'b00);
    ready = 16'h0004; rdata = {16{8'h77}};
    tick();
    ready = '0; rdata = '0;
    chk("t4 done", {a_done, b_done, a_rdata}, {2'b10, 8'h77});
    tick();
    chk("t4 single done", {a_done, b_done}, 2'b00);

    // Reset in WAIT drops the transaction
    b_valid = 1'b1; b_rd_n_wr = 1'b0; b_addr = 20'h6_ABCD; b_wdata = 8'h3C;
    tick();
    b_valid = 1'b0;
    accept = 16'h0040;
    tick();
    accept = '0;
    rst = 1'b1; ready = 16'h0040;
    tick();
    rst = 1'b0; ready = '0;
    chk_all_zero("t5 after reset");
    tick();
    chk("t5 no done", {a_done, b_done}, 2'b00);
    b_valid = 1'b1; b_rd_n_wr = 1'b1; b_addr = 20'h7_0001;
    #1;
    chk("t5 b alone", {a_accept, b_accept}, 2'b01);
    tick();
    b_valid = 1'b0;
    chk("t5 valid", 32'(valid), 32'h0080);
    accept = 16'h0080;
    tick();
    accept = '0;
    ready = 16'h0080; rdata = {16{8'h5C}};
    tick();
    ready = '0; rdata = '0;
    chk("t5 done", {a_done, b_done, b_rdata}, {2'b01, 8'h5C});

    // Channel never completes
    a_valid = 1'b1; a_rd_n_wr = 1'b1; a_addr = 20'h9_0000;
    tick();
    a_valid = 1'b0;
    accept = 16'h0200;
    tick();
    accept = '0;
`ifdef X_SRAM_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen |= a_done | b_done;
      tick();
    end
    chk("t6 early done", 32'(seen), 32'h0);
    chk("t6 timeout done", {a_done, b_done, a_err, a_rdata}, {3'b101, 8'h00});
    chk("t6 valid", 32'(valid), 32'h0);
    tick();
    chk("t6 after", {15'd0, a_done, valid}, 32'h0);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      seen |= a_done | b_done | a_err | b_err;
    end
    chk("t6 no done", 32'(seen), 32'h0);
    b_valid = 1'b1; b_addr = 20'h1_0000;
    #1;
    chk("t6 still busy", {a_accept, b_accept}, 2'b00);
    b_valid = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
